mux_uart_rx: RTL

- Receive half of the diagnostic MUX 0 serial channel; the existing bus model only implements transmit-side writes.
- Deserialises an async 8N1 line into a 4-entry FIFO.
- Exposes status at BASE_ADDR and receive data at BASE_ADDR+1 on the CPU6 19-bit bus.
- Bus read data is combinational, matching the memory model, so CPU6 can poll for input.

---
 rtl/mux_uart_rx.sv | 238 +++++++++++++++++++++++
 1 files changed

// File: rtl/mux_uart_rx.sv
// Receive half of diagnostic MUX 0: async 8N1 deserialiser feeding a small FIFO,
// polled over the CPU6 bus. Define MUX_RX_PARITY_EN for an even-parity bit (11-bit frames).
module mux_uart_rx #(
  parameter int          CLK_DIV    = 16,
  parameter logic [18:0] BASE_ADDR  = 19'h3f200,
  parameter int          FIFO_DEPTH = 4
) (
  input  logic        clock,
  input  logic        reset,
  input  logic [18:0] address,
  input  logic        read_en,
  output logic [7:0]  data_out,
  input  logic        tx_ready,
  input  logic        rx,
  output logic        rx_irq
);

  localparam int TW = $clog2(CLK_DIV);
  localparam int PW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam logic [TW-1:0] T_FULL   = TW'(CLK_DIV - 1);
  localparam logic [TW-1:0] T_HALF   = TW'(CLK_DIV / 2 - 1);
  localparam logic [TW-1:0] T_ONE    = TW'(1);
  localparam logic [PW-1:0] PTR_ONE  = PW'(1);
  localparam logic [PW:0]   CNT_ONE  = (PW + 1)'(1);
  localparam logic [PW:0]   CNT_FULL = (PW + 1)'(FIFO_DEPTH);
  localparam logic [18:0]   DATA_ADDR = BASE_ADDR + 19'd1;

  typedef enum logic [2:0] {
    S_IDLE,
    S_START,
    S_DATA,
    S_PARITY,
    S_STOP
  } state_t;

  logic          rx_meta_q, rx_sync_q;
  logic [1:0]    settle_q;
  logic          armed_q;

  state_t        state_q;
  logic [TW-1:0] timer_q;
  logic [2:0]    bit_idx_q;
  logic [7:0]    shift_q;

  logic [7:0]    mem_q [FIFO_DEPTH];
  logic [PW-1:0] wr_ptr_q, rd_ptr_q;
  logic [PW:0]   count_q, count_d;

  logic          framing_err_q, overrun_q;
  logic          rx_irq_q;

  logic          timer_full, stop_tick;
  logic          stat_sel, data_sel, status_clr;
  logic          fifo_nonempty, fifo_full;
  logic          push, pop, push_ok;
  logic          framing_new, overrun_new;
  logic          parity_err_w, par_bad_w;
  logic [7:0]    status_w;

  // Input synchroniser; the line is only trusted once real samples reach rx_sync_q
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      rx_meta_q <= 1'b1;
      rx_sync_q <= 1'b1;
      settle_q  <= 2'd0;
      armed_q   <= 1'b0;
    end else begin
      rx_meta_q <= rx;
      rx_sync_q <= rx_meta_q;
      if (!settle_q[1])
        settle_q <= settle_q + 2'd1;
      armed_q <= armed_q | (settle_q[1] & rx_sync_q);
    end
  end

  assign timer_full = (timer_q == T_FULL);
  assign stop_tick  = (state_q == S_STOP) && timer_full;

`ifdef MUX_RX_PARITY_EN
  logic par_bad_q;
  logic parity_err_q;
  logic parity_new;

  assign parity_new   = (state_q == S_PARITY) && timer_full && ((^shift_q) != rx_sync_q);
  assign par_bad_w    = par_bad_q;
  assign parity_err_w = parity_err_q;
`else
  assign par_bad_w    = 1'b0;
  assign parity_err_w = 1'b0;
`endif

  // Receiver FSM: IDLE -> START (mid-bit check) -> DATA x8 -> [PARITY] -> STOP
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q   <= S_IDLE;
      timer_q   <= '0;
      bit_idx_q <= 3'd0;
`ifdef MUX_RX_PARITY_EN
      par_bad_q <= 1'b0;
`endif
    end else begin
      case (state_q)
        S_IDLE: begin
          if (armed_q && !rx_sync_q) begin
            state_q <= S_START;
            timer_q <= '0;
          end
        end
        S_START: begin
          if (timer_q == T_HALF) begin
            timer_q   <= '0;
            bit_idx_q <= 3'd0;
`ifdef MUX_RX_PARITY_EN
            par_bad_q <= 1'b0;
`endif
            state_q   <= rx_sync_q ? S_IDLE : S_DATA;
          end else begin
            timer_q <= timer_q + T_ONE;
          end
        end
        S_DATA: begin
          if (timer_full) begin
            timer_q <= '0;
            if (bit_idx_q == 3'd7) begin
`ifdef MUX_RX_PARITY_EN
              state_q <= S_PARITY;
`else
              state_q <= S_STOP;
`endif
            end else begin
              bit_idx_q <= bit_idx_q + 3'd1;
            end
          end else begin
            timer_q <= timer_q + T_ONE;
          end
        end
`ifdef MUX_RX_PARITY_EN
        S_PARITY: begin
          if (timer_full) begin
            timer_q   <= '0;
            par_bad_q <= parity_new;
            state_q   <= S_STOP;
          end else begin
            timer_q <= timer_q + T_ONE;
          end
        end
`endif
        S_STOP: begin
          // Leave at the mid-stop sample so a back-to-back start bit is not missed
          if (timer_full) begin
            timer_q <= '0;
            state_q <= S_IDLE;
          end else begin
            timer_q <= timer_q + T_ONE;
          end
        end
        default: begin
          state_q <= S_IDLE;
          timer_q <= '0;
        end
      endcase
    end
  end

  always_ff @(posedge clock) begin
    if ((state_q == S_DATA) && timer_full)
      shift_q <= {rx_sync_q, shift_q[7:1]};
  end

  assign stat_sel      = (address == BASE_ADDR);
  assign data_sel      = (address == DATA_ADDR);
  assign status_clr    = read_en && stat_sel;
  assign fifo_nonempty = (count_q != '0);
  assign fifo_full     = (count_q == CNT_FULL);
  assign push          = stop_tick && rx_sync_q && !par_bad_w;
  assign pop           = read_en && data_sel && fifo_nonempty;
  assign push_ok       = push && (!fifo_full || pop);
  assign framing_new   = stop_tick && !rx_sync_q;
  assign overrun_new   = push && fifo_full && !pop;

  always_comb begin
    count_d = count_q;
    case ({push_ok, pop})
      2'b10:   count_d = count_q + CNT_ONE;
      2'b01:   count_d = count_q - CNT_ONE;
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clock) begin
    if (push_ok)
      mem_q[wr_ptr_q] <= shift_q;
  end

  // FIFO pointers, sticky error flags and the registered interrupt
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      wr_ptr_q      <= '0;
      rd_ptr_q      <= '0;
      count_q       <= '0;
      framing_err_q <= 1'b0;
      overrun_q     <= 1'b0;
      rx_irq_q      <= 1'b0;
    end else begin
      if (push_ok)
        wr_ptr_q <= wr_ptr_q + PTR_ONE;
      if (pop)
        rd_ptr_q <= rd_ptr_q + PTR_ONE;
      count_q  <= count_d;
      rx_irq_q <= (count_d != '0);
      // A status read clears the flags unless a fresh error lands on the same edge
      framing_err_q <= (framing_err_q & ~status_clr) | framing_new;
      overrun_q     <= (overrun_q & ~status_clr) | overrun_new;
    end
  end

`ifdef MUX_RX_PARITY_EN
  always_ff @(posedge clock or posedge reset) begin
    if (reset)
      parity_err_q <= 1'b0;
    else
      parity_err_q <= (parity_err_q & ~status_clr) | parity_new;
  end
`endif

  assign status_w = {3'b000, parity_err_w, overrun_q, framing_err_q, tx_ready, fifo_nonempty};

  always_comb begin
    data_out = 8'h00;
    if (stat_sel)
      data_out = status_w;
    else if (data_sel && fifo_nonempty)
      data_out = mem_q[rd_ptr_q];
  end

  assign rx_irq = rx_irq_q;

endmodule
